blk_pkt: RTL and testbench
==========================

# blk_pkt

Output packetizer for the sounder RX chain; sits directly downstream of the block averager. It takes the averager's valid-only stream (no backpressure) and buffers it in an internal FIFO. It emits AXI-stream packets of exactly one averaged block (`l` items) with `tlast` on the final item. When buffer space for a whole block is unavailable, the entire block is dropped and counted, so the host only ever sees complete blocks.

## Interface
- `DWIDTH`, 32: bits per sample (sc16 I/Q).
- `NIPC`, 1: samples per item; item width `W = DWIDTH*NIPC`.
- `AWIDTH`, 10: width of `l`.
- `FAWIDTH`, 11: FIFO address width; depth `D = 2^FAWIDTH` items; must be ≥ `AWIDTH`.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `l`, in, `AWIDTH`: block length in items; 0 means `2^AWIDTH`.
- `clear`, in, 1: synchronous clear of `ovf_cnt` only.
- `in_tdata`, in, `W`: item from averager.
- `in_tvalid`, in, 1: item strobe; there is no ready signal and every strobe is one item.
- `out_tdata`, out, `W`: output item.
- `out_tvalid`, out, 1: output valid.
- `out_tlast`, out, 1: last item of a block.
- `out_tready`, in, 1: downstream ready.
- `ovf`, out, 1: one-cycle pulse when a block is dropped.
- `ovf_cnt`, out, 16: dropped-block count; saturates at 0xFFFF.

## Operation
- **Block length.** `len = (l==0) ? 2^AWIDTH : l`. It is latched on the first item of each block; changes to `l` mid-block are ignored until the next block starts.
- **FIFO.** Each FIFO entry is `W` data bits plus 1 `tlast` bit. The FIFO is first-word-fall-through.
  - `count` holds the current occupancy, 0..D.
  - `free = D − count`, using the registered `count`.
  - A push and pop in the same cycle leave `count` unchanged.
- **Write FSM.** Item counter `icnt` runs 0..len−1.
  - **S_IDLE.** On `in_tvalid`, latch `len`.
    - If `free ≥ len`: write the item. If `len==1`, write it with `tlast=1` and stay in S_IDLE. Otherwise set `icnt=1` and go to S_PASS.
    - Else: do not write the item, pulse `ovf`, and increment `ovf_cnt` (saturating). If `len==1`, stay in S_IDLE. Otherwise set `icnt=1` and go to S_DROP.
  - **S_PASS.** On each `in_tvalid`, write the item with `tlast = (icnt==len−1)` and increment `icnt`. When `icnt==len−1`, return to S_IDLE.
  - **S_DROP.** Same item counting as S_PASS, but nothing is written. When `icnt==len−1`, return to S_IDLE.
  - Cycles without `in_tvalid` do not advance the FSM.
- **No overflow within a block.** Space is reserved at block start. During a block, writes total at most `len` and pops only increase space, so a write never hits a full FIFO.
- **Output.** `out_tvalid = !empty`. An item transfers when `out_tvalid & out_tready`. `out_tdata`/`out_tlast` hold stable while `out_tvalid & !out_tready`.
- **`clear`.** Zeroes `ovf_cnt`. If `clear` coincides with a drop, `clear` wins and `ovf_cnt` becomes 0.
- **Packets.** Output packets are always exactly `len` items (the value latched at that block's start), in input order.

## Timing
- **Reset values.** `out_tvalid=0`, `out_tlast=0`, `out_tdata=0`, `ovf=0`, `ovf_cnt=0`. FIFO empty, FSM in S_IDLE, `icnt=0`.
- **Reset mid-operation.** Reset discards FIFO contents and any partial block. The first `in_tvalid` after reset is the first item of a new block.
- **Latency.** With the FIFO empty, `in_tvalid` in cycle n gives `out_tvalid` with that item in cycle n+2.
- **Throughput.** 1 item/cycle in and out.
- **`ovf` timing.** `ovf` is high in cycle n+1 for a dropped block whose first item arrives in cycle n. `ovf_cnt` updates on the same edge.
- **Drop decision.** It uses `count` as registered at the start of cycle n; a pop in cycle n is not credited.
- **Full boundary.** When `count==D`, `out_tvalid=1`. A simultaneous pop and in-block push are legal and keep `count=D`.

## Test plan
1. `l=4`, `out_tready=1`, 8 consecutive items 0..7 → two packets [0..3], [4..7]; `tlast` on items 3 and 7; first output at cycle 2; `ovf` never asserted.
2. `FAWIDTH=4` (D=16), `l=8`, `out_tready=0`, 24 items → first 16 stored, third block dropped. `ovf` pulses once, `ovf_cnt=1`. Then `out_tready=1` → 16 items out, `tlast` at 8th and 16th.
3. `l=1`, 5 items → 5 single-item packets, each with `tlast=1`. Repeat with D=1-equivalent full FIFO and `out_tready=0` → every further item dropped, `ovf_cnt` increments per item.
4. `AWIDTH=4`, `l=0` → packets of 16 items. Change `l` to 3 during block → current packet is still 16 items and the next is 3.
5. `l=4`, `rst` after 2 items of a block → all outputs at reset values next cycle. The following 4 items form one complete packet with `tlast` on the 4th.
6. `l=6`, random `out_tready` (50%), random `in_tvalid` gaps, 1000 blocks → output equals the input minus dropped whole blocks. `ovf_cnt` equals the drop count. `clear` mid-run zeroes it. Saturation is checked with the counter forced near 0xFFFF.

Source files
------------

// File: rtl/blk_pkt_if.sv
// Stream bundle for the output packetizer: valid-only input from the averager
// and an AXI-stream output with tlast.
interface blk_pkt_if #(
   parameter int W = 32
);
   logic [W-1:0] in_tdata;
   logic         in_tvalid;
   logic [W-1:0] out_tdata;
   logic         out_tvalid;
   logic         out_tlast;
   logic         out_tready;

   modport master (
      output in_tdata, in_tvalid, out_tready,
      input  out_tdata, out_tvalid, out_tlast
   );

   modport slave (
      input  in_tdata, in_tvalid, out_tready,
      output out_tdata, out_tvalid, out_tlast
   );
endinterface

// File: rtl/blk_pkt.sv
// Output packetizer: buffers averaged blocks in a FWFT FIFO and emits whole
// blocks as AXI-stream packets, dropping and counting blocks that cannot fit.
module blk_pkt #(
   parameter int DWIDTH  = 32,
   parameter int NIPC    = 1,
   parameter int AWIDTH  = 10,
   parameter int FAWIDTH = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] l,
   input  logic              clear,
   blk_pkt_if.slave          s,
   output logic              ovf,
   output logic [15:0]       ovf_cnt
);
   localparam int W = DWIDTH * NIPC;
   localparam int D = 1 << FAWIDTH;
   localparam logic [FAWIDTH:0] DEPTH = {1'b1, {FAWIDTH{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] icnt, icnt_nxt;
   logic [AWIDTH:0]   len_q, len_nxt, len_in;
   logic              first_last, blk_last;
   logic              push, push_last, drop, pop;
   logic [15:0]       ovf_cnt_q, ovf_cnt_nxt;

   logic [FAWIDTH:0]  count, free;
   logic [FAWIDTH:0]  wptr, rptr;
   logic              wr_en_q, wr_last_q;
   logic [W-1:0]      wr_data_q;
   logic [W:0]        mem [D];
   logic [W:0]        rd_word;

   assign len_in     = (l == '0) ? {1'b1, {AWIDTH{1'b0}}} : {1'b0, l};
   assign first_last = (len_in == (AWIDTH+1)'(1));
   assign blk_last   = ({1'b0, icnt} == len_q - (AWIDTH+1)'(1));
   assign free       = DEPTH - count;

   always_comb begin
      state_nxt = state;
      icnt_nxt  = icnt;
      len_nxt   = len_q;
      push      = 1'b0;
      push_last = 1'b0;
      drop      = 1'b0;
      if (s.in_tvalid) begin
         case (state)
            S_IDLE: begin
               len_nxt = len_in;
               if (free >= (FAWIDTH+1)'(len_in)) begin
                  push      = 1'b1;
                  push_last = first_last;
                  if (!first_last) begin
                     icnt_nxt  = AWIDTH'(1);
                     state_nxt = S_PASS;
                  end
               end else begin
                  drop = 1'b1;
                  if (!first_last) begin
                     icnt_nxt  = AWIDTH'(1);
                     state_nxt = S_DROP;
                  end
               end
            end
            S_PASS, S_DROP: begin
               push      = (state == S_PASS);
               push_last = blk_last;
               if (blk_last) begin
                  icnt_nxt  = '0;
                  state_nxt = S_IDLE;
               end else begin
                  icnt_nxt = icnt + AWIDTH'(1);
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ovf_cnt_nxt = ovf_cnt_q;
      if (clear)
         ovf_cnt_nxt = '0;
      else if (drop && ovf_cnt_q != '1)
         ovf_cnt_nxt = ovf_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         icnt      <= '0;
         len_q     <= '0;
         ovf       <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         icnt      <= icnt_nxt;
         len_q     <= len_nxt;
         ovf       <= drop;
         ovf_cnt_q <= ovf_cnt_nxt;
      end
   end

   assign ovf_cnt = ovf_cnt_q;

   // Accepted items are staged one cycle before the RAM write; count already
   // includes the staged item, so reservations never see stale space.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         wptr    <= '0;
         rptr    <= '0;
         wr_en_q <= 1'b0;
      end else begin
         wr_en_q <= push;
         case ({push, pop})
            2'b10:   count <= count + (FAWIDTH+1)'(1);
            2'b01:   count <= count - (FAWIDTH+1)'(1);
            default: ;
         endcase
         if (wr_en_q) wptr <= wptr + (FAWIDTH+1)'(1);
         if (pop)     rptr <= rptr + (FAWIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      wr_data_q <= s.in_tdata;
      wr_last_q <= push_last;
      if (wr_en_q) mem[wptr[FAWIDTH-1:0]] <= {wr_last_q, wr_data_q};
   end

   assign rd_word      = mem[rptr[FAWIDTH-1:0]];
   assign s.out_tvalid = (wptr != rptr);
   assign s.out_tdata  = s.out_tvalid ? rd_word[W-1:0] : '0;
   assign s.out_tlast  = s.out_tvalid & rd_word[W];
   assign pop          = s.out_tvalid & s.out_tready;
endmodule

// File: tb/tb_blk_pkt.sv
// Bench for blk_pkt with a 16-deep FIFO and 4-bit block length: a cycle
// scoreboard plus table-driven block scenarios and hand-written corner cases.
module tb_blk_pkt;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int FAW   = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic [AW-1:0] l = 4'd4;
   logic          ovf;
   logic [15:0]   ovf_cnt;

   always #5 clk = ~clk;

   blk_pkt_if #(.W(DW)) bus ();

   blk_pkt #(.DWIDTH(DW), .NIPC(1), .AWIDTH(AW), .FAWIDTH(FAW)) dut (
      .clk     (clk),
      .rst     (rst),
      .l       (l),
      .clear   (clear),
      .s       (bus),
      .ovf     (ovf),
      .ovf_cnt (ovf_cnt)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          t;
   } exp_t;

   typedef struct {
      logic [AW-1:0] l;
      int            nitems;
      bit            stall;
      int            exp_out;
      int            exp_lasts;
      int            exp_drops;
   } vec_t;

   exp_t        q[$];
   int          pkt_lens[$];
   int          n_checks = 0, n_errors = 0;
   int          cyc = 0;
   int          m_pos = 0, m_len = 0;
   bit          m_drop = 1'b0, m_ovf = 1'b0;
   logic [15:0] m_cnt = '0;
   int          n_out = 0, n_last = 0, n_ovf = 0, n_in = 0, pkt_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour evaluated once per cycle, away from the active edge.
   task automatic model_step();
      bit exp_valid;
      bit lst;
      int sz0;
      exp_valid = (q.size() > 0) && (q[0].t <= cyc);
      check("out_tvalid", bus.out_tvalid, exp_valid);
      if (exp_valid) begin
         check("out_tdata", bus.out_tdata, q[0].data);
         check("out_tlast", bus.out_tlast, q[0].last);
      end
      check("ovf", ovf, m_ovf);
      check("ovf_cnt", ovf_cnt, m_cnt);
      if (bus.out_tvalid && bus.out_tready) begin
         n_out++;
         pkt_len++;
         if (bus.out_tlast) begin
            n_last++;
            pkt_lens.push_back(pkt_len);
            pkt_len = 0;
         end
      end
      if (ovf) n_ovf++;
      sz0 = q.size();
      if (exp_valid && bus.out_tready) void'(q.pop_front());
      if (rst) begin
         q.delete();
         m_pos = 0; m_ovf = 1'b0; m_cnt = '0; pkt_len = 0;
      end else begin
         m_ovf = 1'b0;
         if (bus.in_tvalid) begin
            n_in++;
            if (m_pos == 0) begin
               m_len  = (l == '0) ? (1 << AW) : int'(l);
               m_drop = (DEPTH - sz0) < m_len;
               m_ovf  = m_drop;
            end
            lst = (m_pos == m_len - 1);
            if (!m_drop) q.push_back('{bus.in_tdata, lst, cyc + 2});
            m_pos = lst ? 0 : m_pos + 1;
         end
         if (clear) m_cnt = '0;
         else if (m_ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      cyc++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] d);
      bus.in_tvalid = 1'b1;
      bus.in_tdata  = d;
      tick(1);
      bus.in_tvalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      bus.out_tready = 1'b1;
      while ((q.size() != 0 || bus.out_tvalid) && k < 300) begin
         tick(1);
         k++;
      end
      check({name, "_drained"}, (q.size() == 0 && !bus.out_tvalid), 1);
      tick(2);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int o0, l0, v0;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      l = v.l;
      bus.out_tready = !v.stall;
      o0 = n_out; l0 = n_last; v0 = n_ovf;
      for (int i = 0; i < v.nitems; i++) send(32'(idx * 256 + i));
      if (v.stall) tick(3);
      drain($sformatf("vec%0d", idx));
      check($sformatf("vec%0d_items", idx), n_out - o0, v.exp_out);
      check($sformatf("vec%0d_tlasts", idx), n_last - l0, v.exp_lasts);
      check($sformatf("vec%0d_ovf_pulses", idx), n_ovf - v0, v.exp_drops);
      check($sformatf("vec%0d_ovf_cnt", idx), ovf_cnt, v.exp_drops);
   endtask

   initial begin
      vec_t vecs[7];
      int   o0, i0, v0, sent;
      bit   did_clear;

      vecs[0] = '{4'd4,  8, 1'b0,  8,  2, 0};
      vecs[1] = '{4'd8, 24, 1'b1, 16,  2, 1};
      vecs[2] = '{4'd1,  5, 1'b0,  5,  5, 0};
      vecs[3] = '{4'd1, 20, 1'b1, 16, 16, 4};
      vecs[4] = '{4'd0, 32, 1'b0, 16,  1, 1};
      vecs[5] = '{4'd3,  9, 1'b1,  9,  3, 0};
      vecs[6] = '{4'd5, 20, 1'b1, 15,  3, 1};

      bus.in_tvalid  = 1'b0;
      bus.in_tdata   = '0;
      bus.out_tready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            model_step();
         end
      join_none

      tick(3);
      check("rst_tvalid", bus.out_tvalid, 0);
      check("rst_tlast", bus.out_tlast, 0);
      check("rst_tdata", bus.out_tdata, 0);
      check("rst_ovf", ovf, 0);
      check("rst_ovf_cnt", ovf_cnt, 0);
      rst = 1'b0;
      tick(2);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Length change mid-block: current block keeps its latched length.
      pkt_lens.delete();
      l = 4'd0;
      bus.out_tready = 1'b1;
      for (int i = 0; i < 5; i++) send(32'h1000 + 32'(i));
      l = 4'd3;
      for (int i = 5; i < 16; i++) send(32'h1000 + 32'(i));
      drain("lchg_a");
      for (int i = 0; i < 3; i++) send(32'h2000 + 32'(i));
      drain("lchg_b");
      check("lchg_npkts", pkt_lens.size(), 2);
      if (pkt_lens.size() == 2) begin
         check("lchg_pkt0_len", pkt_lens[0], 16);
         check("lchg_pkt1_len", pkt_lens[1], 3);
      end

      // Reset two items into a block.
      pkt_lens.delete();
      l = 4'd4;
      send(32'hA0);
      send(32'hA1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_tvalid", bus.out_tvalid, 0);
      check("mid_rst_tlast", bus.out_tlast, 0);
      check("mid_rst_tdata", bus.out_tdata, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_ovf_cnt", ovf_cnt, 0);
      for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i));
      drain("mid_rst");
      check("mid_rst_npkts", pkt_lens.size(), 1);
      if (pkt_lens.size() == 1) check("mid_rst_pkt_len", pkt_lens[0], 4);

      // Saturation and clear-beats-drop with a full FIFO and single-item blocks.
      l = 4'd1;
      bus.out_tready = 1'b0;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(32'h3000 + 32'(i));
      force dut.ovf_cnt_q = 16'hFFFD;
      m_cnt = 16'hFFFD;
      tick(1);
      release dut.ovf_cnt_q;
      for (int i = 0; i < 4; i++) send(32'h4000 + 32'(i));
      tick(1);
      check("sat_ovf_cnt", ovf_cnt, 16'hFFFF);
      bus.in_tvalid = 1'b1;
      bus.in_tdata  = 32'h5000;
      clear = 1'b1;
      tick(1);
      bus.in_tvalid = 1'b0;
      clear = 1'b0;
      check("clr_drop_ovf", ovf, 1);
      check("clr_drop_ovf_cnt", ovf_cnt, 0);
      drain("sat");

      // Random traffic, l=6, 1000 blocks with a clear halfway through.
      l = 4'd6;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      o0 = n_out; i0 = n_in; v0 = n_ovf;
      sent = 0;
      did_clear = 1'b0;
      while (sent < 6000) begin
         bus.out_tready = 1'($urandom_range(0, 1));
         clear = (sent >= 3000) && !did_clear;
         if (clear) did_clear = 1'b1;
         bus.in_tvalid = ($urandom_range(0, 3) != 0);
         bus.in_tdata  = $urandom;
         if (bus.in_tvalid) sent++;
         tick(1);
      end
      bus.in_tvalid = 1'b0;
      clear = 1'b0;
      drain("rand");
      check("rand_items_vs_drops", n_out - o0, (n_in - i0) - 6 * (n_ovf - v0));
      check("rand_drops_seen", (n_ovf - v0) > 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
